// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Define SERIAL_SUBTRACTOR_OVF_EN to compute the signed-overflow flag.
module half_sub (
  input  logic x,
  input  logic y,
  output logic diff,
  output logic bo
);
  assign diff = x ^ y;
  assign bo   = ~x & y;
endmodule

module serial_subtractor #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] d,
  output logic         bout,
  output logic         ovf
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  sa, sb;
  logic [W-2:0]  res;
  logic [W-1:0]  shv;
  logic          borrow;
  logic [CW-1:0] cnt;
  logic          t, b1, dbit, b2;
  logic          borrow_nxt;
  logic          load, last;

  half_sub u_hs0 (
    .x    (sa[0]),
    .y    (sb[0]),
    .diff (t),
    .bo   (b1)
  );

  half_sub u_hs1 (
    .x    (t),
    .y    (borrow),
    .diff (dbit),
    .bo   (b2)
  );

  assign borrow_nxt = b1 | b2;
  assign last       = (cnt == CW'(W-1));
  assign shv        = {dbit, res};
  assign busy       = (state == RUN);
  assign done       = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        load      = start;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      d      <= '0;
      bout   <= 1'b0;
    end else if (load) begin
      sa     <= a;
      sb     <= b;
      res    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (state == RUN) begin
      sa     <= sa >> 1;
      sb     <= sb >> 1;
      res    <= shv[W-1:1];
      borrow <= borrow_nxt;
      cnt    <= cnt + 1'b1;
      if (last) begin
        d    <= shv;
        bout <= borrow_nxt;
      end
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // Operand MSBs are kept since sa/sb are shifted away during RUN
  logic am, bm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      am  <= 1'b0;
      bm  <= 1'b0;
      ovf <= 1'b0;
    end else if (load) begin
      am <= a[W-1];
      bm <= b[W-1];
    end else if (state == RUN && last) begin
      ovf <= (am ^ bm) & (dbit ^ am);
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (W=8).
// Reference results come from plain integer arithmetic.
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, bout, ovf;
  logic [W-1:0] d;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout),
    .ovf   (ovf)
  );

  function automatic logic [W-1:0] ref_d(input logic [W-1:0] x, y);
    return x - y;
  endfunction

  function automatic logic ref_b(input logic [W-1:0] x, y);
    return x < y;
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, y);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    int sx, sy, df;
    sx = int'($signed(x));
    sy = int'($signed(y));
    df = sx - sy;
    return (df > (2**(W-1)) - 1) || (df < -(2**(W-1)));
`else
    return 1'b0;
`endif
  endfunction

  // Caller sits at a negedge; returns at the negedge where done is seen
  task automatic do_op(input logic [W-1:0] x, y, output int lat,
                       output int nbusy, output bit stable);
    logic [W-1:0] d0;
    logic         b0;
    start = 1'b1;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    d0 = d;
    b0 = bout;
    lat = 0;
    nbusy = 0;
    stable = 1'b1;
    while (!done && lat < 3*W) begin
      if (busy) nbusy++;
      if (d !== d0 || bout !== b0) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, bout, ovf} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 0000",
               {busy, done, bout, ovf});
    end
    n_vec++;
    if (d !== '0) begin
      n_err++;
      $display("FAIL reset_d: got %h want 00", d);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [7] = '{8'h05, 8'h03, 8'hFF, 8'h80, 8'h00, 8'h7F, 8'h00};
    logic [W-1:0] tb [7] = '{8'h03, 8'h05, 8'hFF, 8'h01, 8'hFF, 8'hFF, 8'h00};
    int lat, nb;
    bit st;
    logic [W-1:0] ed;
    for (int i = 0; i < 7; i++) begin
      do_op(ta[i], tb[i], lat, nb, st);
      ed = ref_d(ta[i], tb[i]);
      n_vec++;
      if (lat !== W) begin
        n_err++;
        $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, W);
      end
      n_vec++;
      if (nb !== W) begin
        n_err++;
        $display("FAIL dir_busy_cycles[%0d]: got %0d want %0d", i, nb, W);
      end
      n_vec++;
      if (!st) begin
        n_err++;
        $display("FAIL dir_hold_in_run[%0d]: got changed want stable", i);
      end
      n_vec++;
      if (d !== ed) begin
        n_err++;
        $display("FAIL dir_d[%0d]: got %h want %h", i, d, ed);
      end
      n_vec++;
      if (bout !== ref_b(ta[i], tb[i])) begin
        n_err++;
        $display("FAIL dir_bout[%0d]: got %b want %b", i, bout,
                 ref_b(ta[i], tb[i]));
      end
      n_vec++;
      if (ovf !== ref_ovf(ta[i], tb[i])) begin
        n_err++;
        $display("FAIL dir_ovf[%0d]: got %b want %b", i, ovf,
                 ref_ovf(ta[i], tb[i]));
      end
      n_vec++;
      if (busy !== 1'b0) begin
        n_err++;
        $display("FAIL dir_busy_at_done[%0d]: got %b want 0", i, busy);
      end
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || d !== ed) begin
        n_err++;
        $display("FAIL dir_after_done[%0d]: got done=%b d=%h want 0 %h",
                 i, done, d, ed);
      end
    end
  endtask

  task automatic test_ignore_start();
    int i, lat, nb;
    bit st;
    start = 1'b1;
    a = 8'h05;
    b = 8'h03;
    @(negedge clk);
    start = 1'b0;
    i = 0;
    while (!done && i < 3*W) begin
      start = (i == 2);
      a = 8'h10;
      b = 8'h01;
      @(negedge clk);
      i++;
    end
    start = 1'b0;
    n_vec++;
    if (i !== W || d !== 8'h02) begin
      n_err++;
      $display("FAIL ign_start: got lat=%0d d=%h want %0d 02", i, d, W);
    end
    do_op(8'h10, 8'h01, lat, nb, st);
    n_vec++;
    if (lat !== W || d !== 8'h0F) begin
      n_err++;
      $display("FAIL b2b_after_ign: got lat=%0d d=%h want %0d 0f",
               lat, d, W);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    int lat, nb, seen;
    bit st;
    start = 1'b1;
    a = 8'h44;
    b = 8'h11;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, bout, ovf} !== 4'b0000 || d !== '0) begin
      n_err++;
      $display("FAIL midrun_reset: got b=%b dn=%b d=%h bo=%b o=%b want 0",
               busy, done, d, bout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (2*W) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL midrun_no_done: got %0d active cycles want 0", seen);
    end
    do_op(8'h05, 8'h03, lat, nb, st);
    n_vec++;
    if (lat !== W || d !== 8'h02 || bout !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_recover: got lat=%0d d=%h bo=%b want %0d 02 0",
               lat, d, bout, W);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [W-1:0] x, y;
    int lat, nb;
    bit st;
    for (int i = 0; i < 40; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      if (!done || $urandom_range(1) == 0) @(negedge clk);
      do_op(x, y, lat, nb, st);
      n_vec++;
      if (lat !== W || nb !== W || !st) begin
        n_err++;
        $display("FAIL rnd_timing[%0d]: got lat=%0d busy=%0d st=%b want %0d",
                 i, lat, nb, st, W);
      end
      n_vec++;
      if (d !== ref_d(x, y) || bout !== ref_b(x, y)) begin
        n_err++;
        $display("FAIL rnd_result[%0d] %h-%h: got %h/%b want %h/%b",
                 i, x, y, d, bout, ref_d(x, y), ref_b(x, y));
      end
      n_vec++;
      if (ovf !== ref_ovf(x, y)) begin
        n_err++;
        $display("FAIL rnd_ovf[%0d] %h-%h: got %b want %b",
                 i, x, y, ovf, ref_ovf(x, y));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
